// File: rtl/hdmi_cfg_pkg.sv
// Shared constants for the HDMI transmitter configuration sequencer:
// the register/value table, state encodings and a byte-select helper.
package hdmi_cfg_pkg;

  localparam int CFG_LEN = 5;
  localparam int IDX_W   = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;

  // {register, value}; entry 0 powers the transmitter up before anything else
  localparam logic [15:0] CFG_TABLE [CFG_LEN] = '{
    16'h4110,
    16'h9803,
    16'h9AE0,
    16'h9C30,
    16'hAF16
  };

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_BIT,
    TX_ACK,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_GAP,
    SEQ_DONE,
    SEQ_ERR
  } seq_state_t;

  function automatic logic [7:0] cfg_byte(input logic [IDX_W-1:0] idx,
                                          input logic [1:0]       sel,
                                          input logic [7:0]       dev_addr);
    logic [15:0] entry;
    logic [7:0]  result;
    entry = CFG_TABLE[idx];
    case (sel)
      2'd0:    result = dev_addr;
      2'd1:    result = entry[15:8];
      default: result = entry[7:0];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/hdmi_i2c_config_if.sv
// Open-drain I2C pin bundle: pad levels in, pull-down enables out.
interface hdmi_i2c_config_if;
  logic scl_in;
  logic sda_in;
  logic scl_oe;
  logic sda_oe;

  modport master (input scl_in, input sda_in, output scl_oe, output sda_oe);
  modport slave  (output scl_in, output sda_in, input scl_oe, input sda_oe);
endinterface

// File: rtl/i2c_byte_tx.sv
// Sends one I2C byte (optionally framed by START/STOP) on quarter-bit ticks
// and reports the slave's ACK/NACK; a NACK always closes the frame with STOP.
module i2c_byte_tx
  import hdmi_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_in,
  input  logic       tick_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_byte_i,
  input  logic       req_start_i,
  input  logic       req_stop_i,
  output logic       resp_valid_o,
  output logic       resp_nack_o,
  hdmi_i2c_config_if.master bus
);

  tx_state_t   state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic        nack_q, nack_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  data_q;
  logic        load;
  logic        stall;
  logic        step;

  // A released SCL that still reads low is a slave stretching the clock
  assign stall = !scl_oe_q && !bus.scl_in;
  assign step  = tick_i && !stall;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    nack_d       = nack_q;
    scl_oe_d     = scl_oe_q;
    sda_oe_d     = sda_oe_q;
    resp_valid_d = 1'b0;
    load         = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (req_valid_i) begin
          load    = 1'b1;
          stop_d  = req_stop_i;
          nack_d  = 1'b0;
          phase_d = 2'd0;
          bit_d   = 3'd7;
          state_d = req_start_i ? TX_START : TX_BIT;
        end
      end
      TX_START: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: begin
              scl_oe_d = 1'b0;
              sda_oe_d = 1'b0;
            end
            2'd2:    sda_oe_d = 1'b1;
            2'd3:    state_d  = TX_BIT;
            default: ;
          endcase
        end
      end
      TX_BIT: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_oe_d = 1'b1;
            2'd1: sda_oe_d = ~data_q[bit_q];
            2'd2: scl_oe_d = 1'b0;
            default: begin
              if (bit_q == 3'd0) state_d = TX_ACK;
              else               bit_d   = bit_q - 3'd1;
            end
          endcase
        end
      end
      TX_ACK: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_oe_d = 1'b1;
            2'd1: sda_oe_d = 1'b0;
            2'd2: scl_oe_d = 1'b0;
            default: begin
              nack_d = bus.sda_in;
              if (bus.sda_in || stop_q) begin
                state_d = TX_STOP;
              end else begin
                state_d      = TX_IDLE;
                resp_valid_d = 1'b1;
              end
            end
          endcase
        end
      end
      TX_STOP: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_oe_d = 1'b1;
            2'd1: sda_oe_d = 1'b1;
            2'd2: scl_oe_d = 1'b0;
            default: begin
              sda_oe_d     = 1'b0;
              state_d      = TX_IDLE;
              resp_valid_d = 1'b1;
            end
          endcase
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= TX_IDLE;
      phase_q      <= 2'd0;
      bit_q        <= 3'd0;
      stop_q       <= 1'b0;
      nack_q       <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      nack_q       <= nack_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) data_q <= req_byte_i;
  end

  assign req_ready_o  = (state_q == TX_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_nack_o  = nack_q;
  assign bus.scl_oe   = scl_oe_q;
  assign bus.sda_oe   = sda_oe_q;

endmodule

// File: rtl/hdmi_i2c_config.sv
// Writes the HDMI transmitter register table over I2C after reset and on
// each start pulse, retrying NACKed entries up to max_retries times.
module hdmi_i2c_config
  import hdmi_cfg_pkg::*;
#(
  parameter int         sysclk_frequency = 1000,
  parameter logic [7:0] i2c_addr         = 8'h72,
  parameter int         max_retries      = 3
)(
  input  logic clk,
  input  logic reset_in,
  input  logic start,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_oe,
  output logic sda_oe,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int TICK_DIV = (sysclk_frequency / 4 > 0) ? sysclk_frequency / 4 : 1;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RETRY_W  = $clog2(max_retries + 2);

  hdmi_i2c_config_if bus_if ();

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  seq_state_t         seq_q, seq_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         gap_q, gap_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               begin_run;
  logic               req_valid;
  logic               tx_ready;
  logic               resp_valid;
  logic               resp_nack;

  assign bus_if.scl_in = scl_in;
  assign bus_if.sda_in = sda_in;
  assign scl_oe        = bus_if.scl_oe;
  assign sda_oe        = bus_if.sda_oe;

  assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    seq_d     = seq_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    req_valid = 1'b0;
    begin_run = 1'b0;
    case (seq_q)
      SEQ_IDLE: begin_run = 1'b1;
      SEQ_RUN: begin
        if (!pend_q && tx_ready) begin
          req_valid = 1'b1;
          pend_d    = 1'b1;
        end
        if (resp_valid) begin
          pend_d = 1'b0;
          if (resp_nack) begin
            sel_d = 2'd0;
            if (retry_q == RETRY_W'(max_retries)) begin
              seq_d   = SEQ_ERR;
              busy_d  = 1'b0;
              error_d = 1'b1;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              gap_d   = 2'd0;
              seq_d   = SEQ_GAP;
            end
          end else if (sel_q == 2'd2) begin
            sel_d = 2'd0;
            if (idx_q == IDX_W'(CFG_LEN - 1)) begin
              seq_d  = SEQ_DONE;
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              retry_d = '0;
              gap_d   = 2'd0;
              seq_d   = SEQ_GAP;
            end
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      // Bus-free time before any new START, after a good entry or a NACK
      SEQ_GAP: begin
        if (tick) begin
          gap_d = gap_q + 2'd1;
          if (gap_q == 2'd3) seq_d = SEQ_RUN;
        end
      end
      SEQ_DONE, SEQ_ERR: begin_run = start;
      default: seq_d = SEQ_IDLE;
    endcase
    if (begin_run) begin
      seq_d   = SEQ_RUN;
      idx_d   = '0;
      sel_d   = 2'd0;
      retry_d = '0;
      gap_d   = 2'd0;
      pend_d  = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      div_q   <= '0;
      seq_q   <= SEQ_IDLE;
      idx_q   <= '0;
      sel_q   <= 2'd0;
      retry_q <= '0;
      gap_q   <= 2'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  i2c_byte_tx u_byte_tx (
    .clk          (clk),
    .reset_in     (reset_in),
    .tick_i       (tick),
    .req_valid_i  (req_valid),
    .req_ready_o  (tx_ready),
    .req_byte_i   (cfg_byte(idx_q, sel_q, i2c_addr)),
    .req_start_i  (sel_q == 2'd0),
    .req_stop_i   (sel_q == 2'd2),
    .resp_valid_o (resp_valid),
    .resp_nack_o  (resp_nack),
    .bus          (bus_if.master)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
